int_to_float_seq: RTL and testbench
===================================

# int_to_float_seq

Parametrised, sequential signed-integer to floating-point converter, successor to the combinational 8-bit-to-13-bit converter. It normalises one bit per cycle through a small state machine. It optionally rounds to nearest-even and adds a bias to the exponent. It reports zero and inexact flags. It sits between an integer producer and a float consumer, with valid/ready handshakes on both sides.

## Interface
- `INT_W`, 8: signed two's-complement input width (≥2).
- `EXP_W`, 4: exponent field width; must hold `INT_W + EXP_BIAS`.
- `MAN_W`, 8: stored mantissa (fraction) width; the leading 1 is implicit.
- `EXP_BIAS`, 0: constant added to the exponent of non-zero results.
- `ROUND`, 0: 0 = truncate, 1 = round-to-nearest-even.
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: input integer valid.
- `in_ready` out 1: converter can accept an input.
- `in_int` in INT_W: signed integer.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `out_float` out 1+EXP_W+MAN_W: {sign, exponent, mantissa}.
- `out_zero` out 1: result is zero.
- `out_inexact` out 1: non-zero bits were discarded (truncated or rounded).

## Operation
- States: IDLE, NORM, ROUND, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid` the block captures the sign (input MSB).
  - It captures the magnitude as INT_W-bit unsigned. For a negative input this is the two's-complement negation, so the most negative value yields 1 followed by zeros.
  - The exponent counter loads INT_W-1, and the state moves to NORM.
- **NORM**, one shift per cycle:
  - If the magnitude is 0: set the zero flag and go to ROUND.
  - Else if the magnitude MSB is 1: go to ROUND.
  - Else: shift the magnitude left by 1, decrement the exponent counter, and stay in NORM.
- **ROUND**
  - The mantissa is the MAN_W bits directly below the MSB. If INT_W-1 < MAN_W, it is zero-padded on the right.
  - Guard = the next lower bit; sticky = OR of all bits below the guard.
  - `out_inexact` = guard | sticky.
  - ROUND=1: increment the mantissa when guard & (sticky | mantissa LSB). If the increment overflows, the mantissa becomes 0 and the exponent increments by 1.
  - ROUND=0: no increment.
  - The output exponent is the counter plus EXP_BIAS.
  - Load the output registers and go to DONE.
- **Zero input**: `out_float` is all zeros (sign 0, exponent 0, no bias), `out_zero`=1, `out_inexact`=0.
- **DONE**
  - `out_valid`=1.
  - `out_float`, `out_zero` and `out_inexact` are held stable while `out_ready`=0.
  - On `out_ready` go to IDLE.

## Timing
- Reset state: IDLE.
- Reset values: `in_ready`=1, `out_valid`=0, `out_float`=0, `out_zero`=0, `out_inexact`=0.
- Latency: let k = leading zeros of the captured magnitude (k=0 for zero). `out_valid` rises k+2 rising edges after the accepting edge.
  - Minimum 2 edges; maximum INT_W+1 edges (magnitude 1).
- No overlap: `in_ready`=0 from the edge after acceptance until the edge after the output handshake.
  - Throughput is therefore one result per k+3 cycles at best.
  - `in_valid` is ignored outside IDLE.
- Registered outputs: `in_ready` and `out_valid` are decoded from registered state only. There is no combinational path from `out_ready` to `in_ready`.
- Reset mid-operation: deasserting `rst_n` in any state immediately returns the block to IDLE with all outputs at their reset values. The in-flight conversion is discarded.

## Structure
- Package `int_to_float_pkg`:
  - the state enum (IDLE, NORM, ROUND, DONE);
  - a function for the float width, 1+EXP_W+MAN_W;
  - a function for the elaboration-time check that EXP_W can hold INT_W-1+EXP_BIAS+1.
- Sub-module `float_round`: combinational mantissa extraction, guard/sticky and round-nearest-even with carry-out. It is parametrised by INT_W, MAN_W and ROUND, and is reused by later float blocks.
- The top level contains the FSM, the magnitude/exponent registers and the handshake.

## Test plan
- Defaults, `in_int`=8'h80 (-128):
  - `out_float`=13'h1700 (sign 1, exponent 7, mantissa 0), `out_inexact`=0.
  - Latency 2 edges.
- Defaults, `in_int`=5: `out_float`=13'h0240, latency 7 edges.
- Defaults:
  - `in_int`=-1: `out_float`=13'h1000, latency 9 edges.
  - `in_int`=0: `out_float`=0, `out_zero`=1, latency 2 edges.
- INT_W=16, EXP_W=4, MAN_W=4, ROUND=1:
  - 16'h0BC0 → 9'h0B8, inexact=1 (tie, odd, rounds up).
  - 16'h0B40 → 9'h0B6, inexact=1 (tie, even, stays).
  - 16'h0FC0 → 9'h0C0 (mantissa overflow, exponent becomes 12).
- Backpressure and reset:
  - Hold `out_ready`=0 for 5 cycles in DONE: outputs stay stable and `in_ready`=0 throughout.
  - Assert `rst_n`=0 during NORM: `out_valid`=0 and `in_ready`=1 immediately.
  - The next accepted input then converts correctly.

Source files
------------

// File: rtl/int_to_float_pkg.sv
`default_nettype none
// ============================================================================
// Module  : int_to_float_pkg
// Purpose : Shared types and elaboration helpers for the sequential
//           integer-to-float converter family.
// Contents: state_t     - converter FSM state encoding
//           float_w()   - packed float width {sign, exponent, mantissa}
//           exp_w_ok()  - checks the exponent field can hold every exponent
// Revision: 1.0 - initial release
// ============================================================================
package int_to_float_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_NORM  = 2'd1,
        S_ROUND = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic int float_w(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    // The exponent field must represent 0 .. INT_W-1+EXP_BIAS, i.e. at
    // least INT_W-1+EXP_BIAS+1 distinct values.
    function automatic bit exp_w_ok(input int int_w, input int exp_w, input int exp_bias);
        return (int_w - 1 + exp_bias + 1) <= (1 << exp_w);
    endfunction

endpackage : int_to_float_pkg
`default_nettype wire

// File: rtl/float_round.sv
`default_nettype none
// ============================================================================
// Module  : float_round
// Purpose : Combinational mantissa extraction from a normalised magnitude,
//           guard/sticky generation and optional round-to-nearest-even.
// Ports   : i_frac     - magnitude bits below the leading one (INT_W-1 bits)
//           o_man      - rounded (or truncated) MAN_W-bit mantissa
//           o_carry    - mantissa overflowed on rounding; bump the exponent
//           o_inexact  - some non-zero bits were discarded
// Revision: 1.0 - initial release
// ============================================================================
module float_round #(
    parameter int INT_W = 8,
    parameter int MAN_W = 8,
    parameter int ROUND = 0
) (
    input  logic [INT_W-2:0] i_frac,
    output logic [MAN_W-1:0] o_man,
    output logic             o_carry,
    output logic             o_inexact
);

    // Padding the fraction on the right with MAN_W+2 zeros gives one fixed
    // slicing regardless of whether INT_W-1 is wider or narrower than
    // MAN_W: the pad only ever contributes zeros to mantissa/guard/sticky.
    localparam int c_pw = (INT_W - 1) + MAN_W + 2;

    logic [c_pw-1:0]  w_pad;
    logic [MAN_W-1:0] w_man;
    logic             w_guard;
    logic             w_sticky;
    logic             w_inc;

    assign w_pad     = {i_frac, {(MAN_W + 2){1'b0}}};
    assign w_man     = w_pad[c_pw-1 -: MAN_W];
    assign w_guard   = w_pad[c_pw-1-MAN_W];
    assign w_sticky  = |w_pad[c_pw-2-MAN_W:0];
    assign o_inexact = w_guard | w_sticky;

    // Nearest-even: round up above the halfway point, or exactly at it
    // when the kept mantissa is odd.
    assign w_inc = (ROUND != 0) && w_guard && (w_sticky || w_man[0]);

    assign {o_carry, o_man} = {1'b0, w_man} + (MAN_W + 1)'(w_inc);

endmodule : float_round
`default_nettype wire

// File: rtl/int_to_float_seq.sv
`default_nettype none
// ============================================================================
// Module  : int_to_float_seq
// Purpose : Sequential signed-integer to float converter. Normalises one
//           bit per cycle, then truncates or rounds to nearest-even.
// Ports   : clk, rst_n             - clock, asynchronous active-low reset
//           in_valid/in_ready      - input handshake
//           in_int                 - signed two's-complement integer
//           out_valid/out_ready    - output handshake
//           out_float              - {sign, exponent, mantissa}
//           out_zero               - result is zero
//           out_inexact            - non-zero bits were discarded
// Revision: 1.0 - initial release
// ============================================================================
module int_to_float_seq
    import int_to_float_pkg::*;
#(
    parameter int INT_W    = 8,
    parameter int EXP_W    = 4,
    parameter int MAN_W    = 8,
    parameter int EXP_BIAS = 0,
    parameter int ROUND    = 0
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [INT_W-1:0]                  in_int,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [float_w(EXP_W, MAN_W)-1:0]  out_float,
    output logic                              out_zero,
    output logic                              out_inexact
);

    localparam int c_fw    = float_w(EXP_W, MAN_W);
    localparam int c_cnt_w = (INT_W > 2) ? $clog2(INT_W) : 1;

    if (!exp_w_ok(INT_W, EXP_W, EXP_BIAS)) begin : g_exp_w_check
        $error("int_to_float_seq: EXP_W too narrow for INT_W-1+EXP_BIAS");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_sign;
    logic               r_zero;
    logic [INT_W-1:0]   r_mag;
    logic [c_cnt_w-1:0] r_exp;
    logic [c_fw-1:0]    r_out_float;
    logic               r_out_zero;
    logic               r_out_inexact;

    logic               w_accept;
    logic               w_shift;
    logic               w_set_zero;
    logic               w_load_out;
    logic [INT_W-1:0]   w_in_mag;
    logic [MAN_W-1:0]   w_man;
    logic               w_carry;
    logic               w_inexact;
    logic [EXP_W-1:0]   w_exp_out;

    // Negation of the most negative value wraps back onto itself, which is
    // exactly the unsigned magnitude 1 followed by zeros.
    assign w_in_mag = in_int[INT_W-1] ? (~in_int + INT_W'(1)) : in_int;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_shift     = 1'b0;
        w_set_zero  = 1'b0;
        w_load_out  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_NORM;
                end
            end
            S_NORM: begin
                if (r_mag == '0) begin
                    w_set_zero  = 1'b1;
                    w_state_nxt = S_ROUND;
                end else if (r_mag[INT_W-1]) begin
                    w_state_nxt = S_ROUND;
                end else begin
                    w_shift = 1'b1;
                end
            end
            S_ROUND: begin
                w_load_out  = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Rounding / mantissa extraction on the normalised magnitude
    // ------------------------------------------------------------------
    float_round #(
        .INT_W (INT_W),
        .MAN_W (MAN_W),
        .ROUND (ROUND)
    ) u_float_round (
        .i_frac    (r_mag[INT_W-2:0]),
        .o_man     (w_man),
        .o_carry   (w_carry),
        .o_inexact (w_inexact)
    );

    // Mantissa overflow on rounding moves the value up one binade.
    assign w_exp_out = EXP_W'(r_exp) + EXP_W'(w_carry) + EXP_W'(EXP_BIAS);

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign        <= 1'b0;
            r_zero        <= 1'b0;
            r_mag         <= '0;
            r_exp         <= '0;
            r_out_float   <= '0;
            r_out_zero    <= 1'b0;
            r_out_inexact <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sign <= in_int[INT_W-1];
                r_mag  <= w_in_mag;
                r_exp  <= c_cnt_w'(INT_W - 1);
                r_zero <= 1'b0;
            end
            if (w_shift) begin
                r_mag <= r_mag << 1;
                r_exp <= r_exp - c_cnt_w'(1);
            end
            if (w_set_zero) begin
                r_zero <= 1'b1;
            end
            if (w_load_out) begin
                if (r_zero) begin
                    // True zero: no sign, no bias on the exponent.
                    r_out_float   <= '0;
                    r_out_zero    <= 1'b1;
                    r_out_inexact <= 1'b0;
                end else begin
                    r_out_float   <= {r_sign, w_exp_out, w_man};
                    r_out_zero    <= 1'b0;
                    r_out_inexact <= w_inexact;
                end
            end
        end
    end

    // Handshake strobes decode registered state only, so out_ready never
    // reaches in_ready combinationally.
    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = (r_state == S_DONE);
    assign out_float   = r_out_float;
    assign out_zero    = r_out_zero;
    assign out_inexact = r_out_inexact;

endmodule : int_to_float_seq
`default_nettype wire

// File: tb/tb_int_to_float_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_int_to_float_seq
// Purpose : Directed self-checking bench for int_to_float_seq. Exercises a
//           default-parameter instance and a 16-bit rounding instance.
// Revision: 1.0 - initial release
// ============================================================================
module tb_int_to_float_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Default instance: INT_W=8, EXP_W=4, MAN_W=8, truncate
    logic        iv8, ir8, ov8, ordy8, oz8, ox8;
    logic [7:0]  ii8;
    logic [12:0] of8;

    // Rounding instance: INT_W=16, EXP_W=4, MAN_W=4, nearest-even
    logic        iv16, ir16, ov16, ordy16, oz16, ox16;
    logic [15:0] ii16;
    logic [8:0]  of16;

    int_to_float_seq u_dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (iv8),
        .in_ready    (ir8),
        .in_int      (ii8),
        .out_valid   (ov8),
        .out_ready   (ordy8),
        .out_float   (of8),
        .out_zero    (oz8),
        .out_inexact (ox8)
    );

    int_to_float_seq #(
        .INT_W    (16),
        .EXP_W    (4),
        .MAN_W    (4),
        .EXP_BIAS (0),
        .ROUND    (1)
    ) u_dut16 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (iv16),
        .in_ready    (ir16),
        .in_int      (ii16),
        .out_valid   (ov16),
        .out_ready   (ordy16),
        .out_float   (of16),
        .out_zero    (oz16),
        .out_inexact (ox16)
    );

    int n_pass   = 0;
    int n_checks = 0;

    // Selected-instance view used by the conversion task
    logic        sel;
    logic        m_valid, m_in_ready, m_zero, m_ix;
    logic [12:0] m_float;
    assign m_valid    = sel ? ov16 : ov8;
    assign m_in_ready = sel ? ir16 : ir8;
    assign m_zero     = sel ? oz16 : oz8;
    assign m_ix       = sel ? ox16 : ox8;
    assign m_float    = sel ? {4'b0, of16} : of8;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one input, measure edges from acceptance to out_valid and
    // check the result. Leaves the instance in DONE.
    task automatic convert(input bit wide, input logic [15:0] value,
                           input logic [12:0] exp_f, input logic exp_z,
                           input logic exp_ix, input int exp_lat, input string tag);
        int lat;
        sel = wide;
        @(negedge clk);
        if (wide) begin
            iv16 = 1'b1;
            ii16 = value;
        end else begin
            iv8 = 1'b1;
            ii8 = value[7:0];
        end
        @(posedge clk);
        #1;
        iv8  = 1'b0;
        iv16 = 1'b0;
        chk({tag, "_busy"}, 32'(m_in_ready), 32'd0);
        lat = 0;
        while (!m_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_float"}, 32'(m_float), 32'(exp_f));
        chk({tag, "_zero"}, 32'(m_zero), 32'(exp_z));
        chk({tag, "_inexact"}, 32'(m_ix), 32'(exp_ix));
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        ordy8  = 1'b1;
        ordy16 = 1'b1;
        @(posedge clk);
        #1;
        ordy8  = 1'b0;
        ordy16 = 1'b0;
        chk({tag, "_idle_ready"}, 32'(m_in_ready), 32'd1);
        chk({tag, "_idle_valid"}, 32'(m_valid), 32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        iv8    = 1'b0;
        ii8    = '0;
        ordy8  = 1'b0;
        iv16   = 1'b0;
        ii16   = '0;
        ordy16 = 1'b0;
        sel    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(ir8), 32'd1);
        chk("rst_out_valid", 32'(ov8), 32'd0);
        chk("rst_out_float", 32'(of8), 32'd0);
        chk("rst_out_zero", 32'(oz8), 32'd0);
        chk("rst_out_inexact", 32'(ox8), 32'd0);
        chk("rst16_in_ready", 32'(ir16), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Default instance
        convert(1'b0, 16'h0080, 13'h1700, 1'b0, 1'b0, 2, "m128");
        release_out("m128");
        convert(1'b0, 16'h0005, 13'h0240, 1'b0, 1'b0, 7, "p5");
        release_out("p5");
        convert(1'b0, 16'h00FF, 13'h1000, 1'b0, 1'b0, 9, "m1");
        release_out("m1");
        convert(1'b0, 16'h0000, 13'h0000, 1'b1, 1'b0, 2, "zero");
        release_out("zero");
        convert(1'b0, 16'h007F, 13'h06FC, 1'b0, 1'b0, 3, "p127");
        release_out("p127");

        // Rounding instance
        convert(1'b1, 16'h0BC0, 13'h00B8, 1'b0, 1'b1, 6, "tie_odd");
        release_out("tie_odd");
        convert(1'b1, 16'h0B40, 13'h00B6, 1'b0, 1'b1, 6, "tie_even");
        release_out("tie_even");
        convert(1'b1, 16'h0FC0, 13'h00C0, 1'b0, 1'b1, 6, "man_ovf");
        release_out("man_ovf");

        // Backpressure: -3 held in DONE for 5 cycles
        convert(1'b0, 16'h00FD, 13'h1180, 1'b0, 1'b0, 8, "m3");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_float", 32'(of8), 32'h1180);
            chk("bp_valid", 32'(ov8), 32'd1);
            chk("bp_in_ready", 32'(ir8), 32'd0);
        end
        release_out("m3");

        // Reset during NORM
        sel = 1'b0;
        @(negedge clk);
        iv8 = 1'b1;
        ii8 = 8'h01;
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_busy", 32'(ir8), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(ov8), 32'd0);
        chk("mid_rst_in_ready", 32'(ir8), 32'd1);
        chk("mid_rst_float", 32'(of8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        convert(1'b0, 16'h0005, 13'h0240, 1'b0, 1'b0, 7, "post_rst");
        release_out("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_int_to_float_seq
`default_nettype wire
